// File: rtl/joybus_pkg.sv
// joybus_pkg
// Shared constants for the joybus poll scheduler: command opcodes, expected
// reply lengths, FSM state encoding and the command word presented to the PHY.
package joybus_pkg;

   // Command opcodes (first byte on the wire)
   localparam logic [7:0] JB_PROBE     = 8'h00;
   localparam logic [7:0] JB_ORIGIN    = 8'h41;
   localparam logic [7:0] JB_POLL      = 8'h40;
   localparam logic [7:0] JB_POLL_MODE = 8'h03;

   // Expected reply lengths in bytes
   localparam logic [3:0] JB_PROBE_RSP_LEN  = 4'd3;
   localparam logic [3:0] JB_ORIGIN_RSP_LEN = 4'd10;
   localparam logic [3:0] JB_POLL_RSP_LEN   = 4'd8;

   // FSM state encoding
   localparam logic [2:0] ST_IDLE        = 3'd0;
   localparam logic [2:0] ST_PROBE_REQ   = 3'd1;
   localparam logic [2:0] ST_PROBE_WAIT  = 3'd2;
   localparam logic [2:0] ST_ORIGIN_REQ  = 3'd3;
   localparam logic [2:0] ST_ORIGIN_WAIT = 3'd4;
   localparam logic [2:0] ST_POLL_REQ    = 3'd5;
   localparam logic [2:0] ST_POLL_WAIT   = 3'd6;

   // Command as seen by the PHY: length in bytes plus left-aligned bytes
   typedef struct packed {
      logic [1:0]  len;
      logic [23:0] data;
   } jb_cmd_t;

   // Command issued from a given REQ state; all-zero outside REQ states so
   // the outputs idle at 0.
   function automatic jb_cmd_t jb_cmd_for(input logic [2:0] st, input logic rumble);
      jb_cmd_t c;
      c = '0;
      case (st)
         ST_PROBE_REQ:  c = '{len: 2'd1, data: {JB_PROBE, 16'h0000}};
         ST_ORIGIN_REQ: c = '{len: 2'd1, data: {JB_ORIGIN, 16'h0000}};
         ST_POLL_REQ:   c = '{len: 2'd3, data: {JB_POLL, JB_POLL_MODE, 7'b0, rumble}};
         default:       c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/joybus_period_timer.sv
// joybus_period_timer
// Free-running poll period counter plus a response watchdog down-counter.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wdog_reload    load the watchdog with a full window (command transfer)
//   wdog_run       watchdog counts down while high (WAIT states)
//   tick           1-cycle pulse when the period counter wraps
//   wdog_expired   high on the last allowed cycle of a running window
module joybus_period_timer #(
   parameter int POLL_PERIOD_CYC = 1_000_000,
   parameter int RSP_WDOG_CYC    = 50_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic wdog_reload,
   input  logic wdog_run,
   output logic tick,
   output logic wdog_expired
);

   localparam int PW = $clog2(POLL_PERIOD_CYC + 1);
   localparam int WW = $clog2(RSP_WDOG_CYC + 1);

   logic [PW-1:0] period_cnt;
   logic [WW-1:0] wdog_cnt;

   assign tick         = (period_cnt == PW'(POLL_PERIOD_CYC - 1));
   // Loaded with N-1 so that expiry lands on the N-th cycle spent waiting.
   assign wdog_expired = wdog_run && (wdog_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_cnt <= '0;
      end else if (tick) begin
         period_cnt <= '0;
      end else begin
         period_cnt <= period_cnt + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdog_cnt <= '0;
      end else if (wdog_reload) begin
         wdog_cnt <= WW'(RSP_WDOG_CYC - 1);
      end else if (wdog_run && (wdog_cnt != '0)) begin
         wdog_cnt <= wdog_cnt - WW'(1);
      end
   end

endmodule

// File: rtl/joybus_poll_scheduler.sv
// joybus_poll_scheduler
// Drives the joybus PHY through probe -> origin -> periodic poll and owns the
// link state presented to game logic.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   enable                             allow new transactions to start
//   rumble                             poll rumble bit, sampled when a poll starts
//   cmd_valid/cmd_ready/cmd_len/cmd_data   command handshake to the PHY
//   rsp_valid/rsp_timeout/rsp_len/rsp_data response from the PHY (right-aligned)
//   connected                          controller present and origin fetched
//   ctrl_data                          last good poll report, byte0 in [63:56]
//   origin_data                        origin bytes 2..7
//   dev_id                             probe reply bytes 0..1
//   frame_valid                        1-cycle pulse with each new ctrl_data
//   miss_cnt                           consecutive failed polls (saturating)
module joybus_poll_scheduler
   import joybus_pkg::*;
#(
   parameter int POLL_PERIOD_CYC = 1_000_000,
   parameter int RSP_WDOG_CYC    = 50_000,
   parameter int MAX_MISSES      = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        rumble,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [1:0]  cmd_len,
   output logic [23:0] cmd_data,
   input  logic        rsp_valid,
   input  logic        rsp_timeout,
   input  logic [3:0]  rsp_len,
   input  logic [79:0] rsp_data,
   output logic        connected,
   output logic [63:0] ctrl_data,
   output logic [47:0] origin_data,
   output logic [15:0] dev_id,
   output logic        frame_valid,
   output logic [1:0]  miss_cnt
);

   logic [2:0] state_q, state_d;
   logic       need_origin_q;
   logic       rumble_q;
   logic       tick, wdog_expired;
   logic       xfer, in_wait, rsp_ok, rsp_fail;
   logic [3:0] exp_len;
   logic [1:0] miss_next;
   jb_cmd_t    cmd;

   // Origin reply bytes 0..1 (button state at origin time) are not kept.
   logic unused_rsp_bits;
   assign unused_rsp_bits = ^rsp_data[79:64];

   joybus_period_timer #(
      .POLL_PERIOD_CYC (POLL_PERIOD_CYC),
      .RSP_WDOG_CYC    (RSP_WDOG_CYC)
   ) u_timer (
      .clk          (clk),
      .reset_n      (reset_n),
      .wdog_reload  (xfer),
      .wdog_run     (in_wait),
      .tick         (tick),
      .wdog_expired (wdog_expired)
   );

   // Command outputs decode straight from the state register, so an
   // asynchronous reset drops cmd_valid immediately.
   assign cmd       = jb_cmd_for(state_q, rumble_q);
   assign cmd_valid = (state_q == ST_PROBE_REQ) || (state_q == ST_ORIGIN_REQ) ||
                      (state_q == ST_POLL_REQ);
   assign cmd_len   = cmd.len;
   assign cmd_data  = cmd.data;
   assign xfer      = cmd_valid && cmd_ready;

   assign in_wait = (state_q == ST_PROBE_WAIT) || (state_q == ST_ORIGIN_WAIT) ||
                    (state_q == ST_POLL_WAIT);

   always_comb begin
      exp_len = 4'd0;
      case (state_q)
         ST_PROBE_WAIT:  exp_len = JB_PROBE_RSP_LEN;
         ST_ORIGIN_WAIT: exp_len = JB_ORIGIN_RSP_LEN;
         ST_POLL_WAIT:   exp_len = JB_POLL_RSP_LEN;
         default:        exp_len = 4'd0;
      endcase
   end

   // Timeout beats a simultaneous rsp_valid; a good reply on the final
   // watchdog cycle still counts as arrived in time.
   assign rsp_ok   = in_wait && rsp_valid && !rsp_timeout && (rsp_len == exp_len);
   assign rsp_fail = in_wait && !rsp_ok && (rsp_timeout || rsp_valid || wdog_expired);

   assign miss_next = (miss_cnt == 2'(MAX_MISSES)) ? miss_cnt : miss_cnt + 2'd1;

   always_comb begin
      // NOTE: state_d takes a default before the case so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (tick && enable) begin
               if (!connected)         state_d = ST_PROBE_REQ;
               else if (need_origin_q) state_d = ST_ORIGIN_REQ;
               else                    state_d = ST_POLL_REQ;
            end
         end
         ST_PROBE_REQ:   if (xfer) state_d = ST_PROBE_WAIT;
         ST_ORIGIN_REQ:  if (xfer) state_d = ST_ORIGIN_WAIT;
         ST_POLL_REQ:    if (xfer) state_d = ST_POLL_WAIT;
         ST_PROBE_WAIT: begin
            if (rsp_ok)        state_d = ST_ORIGIN_REQ;
            else if (rsp_fail) state_d = ST_IDLE;
         end
         ST_ORIGIN_WAIT, ST_POLL_WAIT: begin
            if (rsp_ok || rsp_fail) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every
         // register samples the pre-edge values regardless of block order.
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         need_origin_q <= 1'b0;
         rumble_q      <= 1'b0;
         connected     <= 1'b0;
         ctrl_data     <= '0;
         origin_data   <= '0;
         dev_id        <= '0;
         frame_valid   <= 1'b0;
         miss_cnt      <= '0;
      end else begin
         frame_valid <= 1'b0;

         // Rumble is frozen for the whole poll command.
         if ((state_q == ST_IDLE) && (state_d == ST_POLL_REQ)) begin
            rumble_q <= rumble;
         end

         case (state_q)
            ST_PROBE_WAIT: begin
               if (rsp_ok)        dev_id    <= rsp_data[23:8];
               else if (rsp_fail) connected <= 1'b0;
            end
            ST_ORIGIN_WAIT: begin
               if (rsp_ok) begin
                  origin_data   <= rsp_data[63:16];
                  connected     <= 1'b1;
                  need_origin_q <= 1'b0;
               end else if (rsp_fail) begin
                  connected <= 1'b0;
               end
            end
            ST_POLL_WAIT: begin
               if (rsp_ok) begin
                  ctrl_data     <= rsp_data[63:0];
                  frame_valid   <= 1'b1;
                  miss_cnt      <= '0;
                  // Report byte0 bit5: controller asks for its origin again.
                  need_origin_q <= rsp_data[61];
               end else if (rsp_fail) begin
                  miss_cnt <= miss_next;
                  if (miss_next == 2'(MAX_MISSES)) begin
                     connected     <= 1'b0;
                     ctrl_data     <= '0;
                     origin_data   <= '0;
                     need_origin_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
